// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//
// Contents:
//   NOP_INST      - instruction word presented on a bubble
//   fetch_state_t - issue FSM states (IDLE, REQ, DROP)
//   fetch_entry_t - one prefetched {pc, inst} pair as held in the FIFO
package if_pkg;

  localparam logic [31:0] NOP_INST = 32'h0;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// Prefetch FIFO holding fetch_entry_t words between the memory port and
// the IF/ID output register.
//
// Parameters:
//   DEPTH     - number of entries, power of 2 and at least 2
// Ports:
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset
//   push      in   write wr_entry (ignored when full)
//   pop       in   drop the head entry (ignored when empty)
//   flush     in   empty the FIFO; wins over push and pop
//   wr_entry  in   entry to write
//   rd_entry  out  current head entry
//   count     out  number of valid entries
//   full      out  count == DEPTH
//   empty     out  count == 0
module if_fetch_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wr_entry,
  output fetch_entry_t             rd_entry,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_CNT = (PW + 1)'(DEPTH);

  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);
  assign rd_entry = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset; the count decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wr_entry;
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage. Issues word reads over a req/ack handshake,
// buffers returned words in a prefetch FIFO and presents one PC/instruction
// pair per cycle to the IF/ID register. A redirect from WB flushes all
// buffered and in-flight work and restarts fetch at the redirect target.
//
// Optional feature macro: IF_FETCH_BYPASS_EN
//   When defined, ack data goes straight to the output register if the FIFO
//   is empty, the stage is not stalled and no redirect is present.
//
// Parameters:
//   RESET_PC   - first fetch address after reset
//   PC_INC     - sequential increment (word addressing)
//   FIFO_DEPTH - prefetch entries, power of 2 and at least 2
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   imem_req/addr    read request (held until ack) and its address
//   imem_ack/rdata   read completion and returned word
//   redirect_valid   taken branch/jump resolved in WB
//   redirect_pc      redirect target
//   stall            hold IF/ID outputs
//   PC_if/inst_in    presented PC and instruction
//   inst_valid       1 = real instruction, 0 = bubble
module if_fetch
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] PC_INC     = 32'h0000_0001,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] PC_if,
  output logic [31:0] inst_in,
  output logic        inst_valid
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

  fetch_state_t  state;
  fetch_state_t  state_next;
  logic [31:0]   fetch_pc;
  logic [31:0]   stale_addr;

  logic          accept;
  logic          bypass;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_after;
  fetch_entry_t  fifo_wr;
  fetch_entry_t  fifo_rd;

  // DROP keeps showing the abandoned address until memory completes it.
  assign imem_req  = (state == REQ) || (state == DROP);
  assign imem_addr = (state == DROP) ? stale_addr : fetch_pc;

  // Only an ack in REQ carries a word we want; DROP acks are thrown away.
  assign accept = (state == REQ) && imem_ack;

`ifdef IF_FETCH_BYPASS_EN
  assign bypass = accept && fifo_empty && !stall && !redirect_valid;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_push    = accept && !redirect_valid && !bypass;
  assign fifo_pop     = !stall && !redirect_valid && !fifo_empty;
  assign fifo_wr.pc   = fetch_pc;
  assign fifo_wr.inst = imem_rdata;
  assign count_after  = fifo_count + CW'(fifo_push) - CW'(fifo_pop);

  if_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .flush    (redirect_valid),
    .wr_entry (fifo_wr),
    .rd_entry (fifo_rd),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Issue FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic. A redirect overrides everything: an unacked request
  // must still be completed by memory, so it is parked in DROP.
  always_comb begin
    state_next = state;
    if (redirect_valid) begin
      if (imem_req && !imem_ack) state_next = DROP;
      else                       state_next = REQ;
    end else begin
      case (state)
        IDLE:    if (!fifo_full) state_next = REQ;
        REQ:     if (imem_ack) state_next = (count_after < DEPTH_CNT) ? REQ : IDLE;
        DROP:    if (imem_ack) state_next = REQ;
        default: state_next = IDLE;
      endcase
    end
  end

  // Fetch PC and the address remembered for a request being dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc   <= RESET_PC;
      stale_addr <= RESET_PC;
    end else begin
      if (redirect_valid && imem_req && !imem_ack) stale_addr <= imem_addr;
      if (redirect_valid)  fetch_pc <= redirect_pc;
      else if (accept)     fetch_pc <= fetch_pc + PC_INC;
    end
  end

  // IF/ID output register. PC_if holds across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC_if      <= 32'h0;
      inst_in    <= NOP_INST;
      inst_valid <= 1'b0;
    end else if (redirect_valid) begin
      inst_in    <= NOP_INST;
      inst_valid <= 1'b0;
    end else if (!stall) begin
      if (bypass) begin
        PC_if      <= fetch_pc;
        inst_in    <= imem_rdata;
        inst_valid <= 1'b1;
      end else if (!fifo_empty) begin
        PC_if      <= fifo_rd.pc;
        inst_in    <= fifo_rd.inst;
        inst_valid <= 1'b1;
      end else begin
        inst_in    <= NOP_INST;
        inst_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage that generates the PC/instruction pair consumed by the IF/ID pipeline register. It issues word reads to instruction memory over a req/ack handshake and buffers returned words in a small prefetch FIFO. It presents one instruction per cycle to IF/ID and discards all in-flight and buffered work on a redirect from the branch/jump resolution logic in WB.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- PC_INC, 1: sequential PC increment. Addressing is by word.
- FIFO_DEPTH, 2: prefetch entries. Must be a power of 2 and at least 2.

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  read request, held until ack
- imem_addr  out  32  read address, stable while imem_req=1
- imem_ack  in  1  read complete; imem_rdata valid this cycle
- imem_rdata  in  32  instruction word
- redirect_valid  in  1  taken jump/branch resolved in WB
- redirect_pc  in  32  redirect target
- stall  in  1  hold IF/ID outputs (hazard)
- PC_if  out  32  PC of presented instruction
- inst_in  out  32  presented instruction word
- inst_valid  out  1  1 = real instruction, 0 = bubble

## Operation
- Reset values: imem_req=0, imem_addr=RESET_PC, PC_if=0, inst_in=32'h0, inst_valid=0, state IDLE, FIFO empty, fetch PC=RESET_PC.
- Issue FSM has three states:
  - IDLE → REQ when (fifo_count + 0) < FIFO_DEPTH.
  - REQ: imem_req=1 and imem_addr=fetch PC. On ack: push {fetch PC, imem_rdata}, fetch PC += PC_INC (mod 2^32), then stay in REQ if count after push < DEPTH, else go to IDLE.
  - DROP: imem_req=1 and the address is held. On ack the data is discarded and the FSM goes to REQ.
- One request is outstanding at most. Space is checked before issue, so a push never finds the FIFO full.
- Output register, when not stalled:
  - FIFO non-empty: pop the head into PC_if/inst_in and set inst_valid=1.
  - FIFO empty: inst_in=32'h0 (NOP), inst_valid=0, PC_if holds.
- stall=1: outputs and FIFO head hold. Fetching continues until the FIFO is full.
- Redirect has priority over stall and ack. At the edge where redirect_valid=1:
  - FIFO is flushed.
  - Outputs become a bubble (inst_in=0, inst_valid=0).
  - fetch PC becomes redirect_pc.
  - FSM goes to DROP if a request is outstanding and imem_ack=0. Otherwise it goes to REQ, and any ack data in that cycle is discarded.
- In DROP, imem_addr keeps the stale address until the ack. The new address is presented in the cycle after the drop.
- Asserting rst_n low mid-transaction clears everything immediately. imem_req drops with it, and the memory must abandon the request.

## Timing
- Reset released before edge 0 → imem_req=1 with addr RESET_PC after edge 0.
- Zero-wait memory (ack in the same cycle as req) gives 1 instruction per cycle sustained.
- Ack-to-output latency:
  - Without bypass: data is written to the FIFO at edge N and appears on PC_if/inst_in after edge N+1.
  - With bypass (see Configuration): data appears after edge N.
- Redirect at edge R (no outstanding request): req with redirect_pc after edge R; the first redirected instruction is valid after edge R+2 (R+1 with bypass).
- Simultaneous push and pop with count=1 leaves count=1.
- FIFO pointers wrap modulo FIFO_DEPTH.

## Configuration
- IF_FETCH_BYPASS_EN:
  - Defined: if the FIFO is empty, stall=0 and no redirect, ack data loads the output register directly at the ack edge without being pushed.
  - Undefined: all data passes through the FIFO, adding one cycle.
- Redirect, stall and handshake behaviour are identical in both builds.

## Structure
- Package if_pkg:
  - NOP_INST = 32'h0
  - fetch_state_t enum {IDLE, REQ, DROP}
  - fetch_entry_t struct {pc[31:0], inst[31:0]}
- Sub-module if_fetch_fifo: a FIFO_DEPTH-entry fetch_entry_t FIFO with push/pop/flush, count and full/empty, where flush has priority.

## Test plan
- Zero-wait memory returning inst=addr+32'hA000, no stall → PC_if steps 0,1,2,3 on consecutive cycles, inst_valid=1 from the first presented instruction onward.
- Memory acks 3 cycles after req → imem_addr is held stable for all cycles; each instruction is presented once, followed by bubbles (inst_valid=0, inst_in=0).
- stall=1 for 5 cycles with zero-wait memory → outputs are frozen and exactly FIFO_DEPTH further reads are issued, then imem_req=0. Releasing stall resumes without loss or duplication.
- redirect_valid with redirect_pc=32'h40 while a request to 5 is outstanding (ack 2 cycles later) → that ack data is dropped; the next req addr is 32'h40 and PC_if=32'h40 is the next valid output.
- Redirect and ack in the same cycle, and separately rst_n pulsed low mid-request → ack data is discarded; after reset all outputs return to their reset values and fetch restarts at RESET_PC.
- Fetch PC 32'hFFFF_FFFF with PC_INC=1 → next imem_addr is 32'h0.
